// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, byte-enable constants and grant port encoding for the data-memory arbiter
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;
  typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_e;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// arb_starve_counter: saturating conflict counter (clk, rst, i_clr, i_inc in; o_at_max out when count == MAX)
module arb_starve_counter #(
  parameter int MAX = 3,
  parameter int W = MAX > 0 ? $clog2(MAX + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);
  logic [W-1:0] r_cnt;
  assign o_at_max = r_cnt == W'(MAX);
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc && !o_at_max) r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: ls-priority arbiter with if starvation guard over a single-port memory (if_*/ls_* requesters, mem_* memory side, 1-cycle registered read data)
module dmem_arbiter #(
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wea,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_pkg::*;
  port_e w_sel;
  logic w_at_max;
  logic w_ls_rd;
  logic [ADDR_W-1:0] w_addr;
  logic r_if_rvalid;
  logic r_ls_rvalid;
  assign if_gnt = !rst && if_req && (!ls_req || w_at_max);
  assign ls_gnt = !rst && ls_req && !if_gnt;
  assign w_ls_rd = ls_gnt && !ls_we;
  assign w_sel = ls_gnt ? PORT_LS : PORT_IF;
  assign w_addr = w_sel == PORT_LS ? ls_addr : if_addr;
  assign mem_addr = w_addr & ~ADDR_W'(3);
  assign mem_wea = (ls_gnt && ls_we) ? ls_be : 4'b0000;
  assign mem_wdata = ls_wdata;
  // a response in flight when reset arrives is dropped, not delivered
  assign if_rvalid = r_if_rvalid && !rst;
  assign ls_rvalid = r_ls_rvalid && !rst;
  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (if_gnt),
    .i_inc   (ls_gnt && if_req),
    .o_at_max(w_at_max)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      r_if_rvalid <= if_gnt;
      r_ls_rvalid <= w_ls_rd;
      if (if_gnt) if_rdata <= mem_rdata;
      if (w_ls_rd) ls_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural memory and a STARVE_MAX=0 instance
module tb_dmem_arbiter;
  import dmem_pkg::*;
  typedef struct {logic [31:0] data; int due;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [3:0] ls_be = 4'b0;
  logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wea;
  logic if_req0 = 1'b0, ls_req0 = 1'b0;
  logic if_gnt0, if_rvalid0, ls_gnt0, ls_rvalid0;
  logic [31:0] if_rdata0, ls_rdata0, mem_addr0, mem_wdata0;
  logic [31:0] mem_rdata0 = 32'h0;
  logic [3:0] mem_wea0;
  logic [31:0] mem [0:255];
  exp_t ifq[$];
  exp_t lsq[$];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++) if (mem_wea[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  dmem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .ls_req(ls_req), .ls_we(ls_we),
    .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wea(mem_wea), .mem_rdata(mem_rdata)
  );
  dmem_arbiter #(.STARVE_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .if_req(if_req0), .if_addr(32'h0000_0010), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0), .ls_req(ls_req0), .ls_we(1'b0),
    .ls_be(4'b0000), .ls_addr(32'h0000_0020), .ls_wdata(32'h0), .ls_gnt(ls_gnt0),
    .ls_rvalid(ls_rvalid0), .ls_rdata(ls_rdata0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_wea(mem_wea0), .mem_rdata(mem_rdata0)
  );

  always @(negedge clk) begin
    automatic logic e;
    automatic exp_t d;
    e = ifq.size() > 0 && ifq[0].due == cyc;
    nvec++;
    if (if_rvalid !== e) begin nerr++; $display("FAIL if_rvalid cyc %0d: got %b want %b", cyc, if_rvalid, e); end
    if (e) begin
      d = ifq.pop_front();
      nvec++;
      if (if_rdata !== d.data) begin nerr++; $display("FAIL if_rdata cyc %0d: got %h want %h", cyc, if_rdata, d.data); end
    end
    e = lsq.size() > 0 && lsq[0].due == cyc;
    nvec++;
    if (ls_rvalid !== e) begin nerr++; $display("FAIL ls_rvalid cyc %0d: got %b want %b", cyc, ls_rvalid, e); end
    if (e) begin
      d = lsq.pop_front();
      nvec++;
      if (ls_rdata !== d.data) begin nerr++; $display("FAIL ls_rdata cyc %0d: got %h want %h", cyc, ls_rdata, d.data); end
    end
  end

  task automatic test_reset();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_be = BE_WORD;
    if_addr = 32'h100; ls_addr = 32'h100;
    #1;
    nvec++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_wea !== 4'b0) begin
      nerr++; $display("FAIL reset_mask: gnt if/ls %b%b wea %b want 00 0000", if_gnt, ls_gnt, mem_wea);
    end
    @(posedge clk); #1;
    nvec++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      nerr++; $display("FAIL reset_rvalid: %b%b want 00", if_rvalid, ls_rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0; ls_we = 1'b0;
    #1;
    nvec++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      nerr++; $display("FAIL reset_release_gnt: if/ls %b%b want 01", if_gnt, ls_gnt);
    end
    lsq.push_back('{32'hDEAD_BEEF, cyc + 1});
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 32'h0000_0103;
    #1;
    nvec++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_addr !== 32'h100 || mem_wea !== 4'b0) begin
      nerr++; $display("FAIL if_only: gnt %b%b addr %h wea %b want 10 00000100 0000", if_gnt, ls_gnt, mem_addr, mem_wea);
    end
    ifq.push_back('{32'hDEAD_BEEF, cyc + 1});
    @(posedge clk); #1;
    if_req = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (if_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL if_rdata_hold: got %h want deadbeef", if_rdata); end
  endtask

  task automatic test_starve();
    logic ei;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      ei = (i % 4) == 3;
      #1;
      nvec++;
      if (if_gnt !== ei || ls_gnt !== !ei || mem_addr !== (ei ? 32'h100 : 32'h40)) begin
        nerr++; $display("FAIL starve_pattern[%0d]: gnt if/ls %b%b addr %h want %b%b", i, if_gnt, ls_gnt, mem_addr, ei, !ei);
      end
      if (ei) ifq.push_back('{32'hDEAD_BEEF, cyc + 1});
      else lsq.push_back('{32'hAAAA_AAAA, cyc + 1});
      @(posedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = BE_HALF_LO; ls_wdata = 32'h1234_5678; ls_addr = 32'h40;
    #1;
    nvec++;
    if (ls_gnt !== 1'b1 || mem_wea !== BE_HALF_LO || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678) begin
      nerr++; $display("FAIL store_drive: gnt %b wea %b addr %h wdata %h", ls_gnt, mem_wea, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    ls_we = 1'b0;
    #1;
    nvec++;
    if (ls_gnt !== 1'b1 || mem_wea !== 4'b0) begin nerr++; $display("FAIL load_wea: gnt %b wea %b want 1 0000", ls_gnt, mem_wea); end
    lsq.push_back('{32'hAAAA_5678, cyc + 1});
    @(posedge clk); #1;
    ls_we = 1'b1; ls_be = 4'b0000; ls_addr = 32'h101; ls_wdata = 32'hFFFF_FFFF;
    #1;
    nvec++;
    if (ls_gnt !== 1'b1 || mem_wea !== 4'b0 || mem_addr !== 32'h100) begin
      nerr++; $display("FAIL store_be0: gnt %b wea %b addr %h want 1 0000 00000100", ls_gnt, mem_wea, mem_addr);
    end
    @(posedge clk); #1;
    ls_we = 1'b0;
    lsq.push_back('{32'hDEAD_BEEF, cyc + 1});
    @(posedge clk); #1;
    ls_req = 1'b0; ls_we = 1'b1; ls_be = BE_WORD; if_addr = 32'h207;
    #1;
    nvec++;
    if (ls_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_wea !== 4'b0 || mem_addr !== 32'h204) begin
      nerr++; $display("FAIL idle_drive: gnt %b%b wea %b addr %h want 00 0000 00000204", if_gnt, ls_gnt, mem_wea, mem_addr);
    end
    @(posedge clk); #1;
    ls_we = 1'b0;
  endtask

  task automatic test_reset_drop();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    nvec++;
    if (if_gnt !== 1'b1) begin nerr++; $display("FAIL drop_gnt: got %b want 1", if_gnt); end
    @(posedge clk); #1;
    if_req = 1'b0; rst = 1'b1;
    #1;
    nvec++;
    if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL drop_rvalid: got %b want 0", if_rvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    nvec++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
      nerr++; $display("FAIL drop_after: rvalid %b if_rdata %h ls_rdata %h want 0 0 0", if_rvalid, if_rdata, ls_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
      #1;
      nvec++;
      if (if_gnt !== (i == 3) || ls_gnt !== (i != 3)) begin
        nerr++; $display("FAIL drop_starve[%0d]: gnt if/ls %b%b", i, if_gnt, ls_gnt);
      end
      if (i == 3) ifq.push_back('{32'hDEAD_BEEF, cyc + 1});
      else lsq.push_back('{32'hAAAA_5678, cyc + 1});
      @(posedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_starve_zero();
    if_req0 = 1'b1; ls_req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++;
      if (if_gnt0 !== 1'b1 || ls_gnt0 !== 1'b0) begin
        nerr++; $display("FAIL starve0[%0d]: gnt if/ls %b%b want 10", i, if_gnt0, ls_gnt0);
      end
      @(posedge clk); #1;
    end
    if_req0 = 1'b0;
    #1;
    nvec++;
    if (ls_gnt0 !== 1'b1 || if_gnt0 !== 1'b0) begin nerr++; $display("FAIL starve0_ls: gnt if/ls %b%b want 01", if_gnt0, ls_gnt0); end
    @(posedge clk); #1;
    ls_req0 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'hDEAD_BEEF;
    mem[16] = 32'hAAAA_AAAA;
    test_reset();
    test_if_only();
    test_starve();
    test_store_load();
    test_reset_drop();
    test_starve_zero();
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (ifq.size() != 0 || lsq.size() != 0) begin
      nerr++; $display("FAIL pending_responses: if %0d ls %0d want 0 0", ifq.size(), lsq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
